// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and encodings for the pipeline hazard sequencer.
//               Holds the memory-wait FSM state enum and the ALU operand
//               forward-select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Memory-wait sequencer states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    // ALU operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // writeback-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // memory-stage result

endpackage : mips_pkg
`default_nettype wire

// File: rtl/hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer_if
// Description : Bundle of pipeline-side signals seen and driven by the hazard
//               sequencer.
//               master : pipeline side (drives register ids / enables, reads
//                        stall / flush / forward controls)
//               slave  : hazard sequencer side
//               Inputs : RsD, RtD, RsE, RtE, WriteReg{E,M,W}, RegWrite{E,M,W},
//                        MemtoReg{E,M}, BranchD, PCSrcD, MemReqM, MemReadyM,
//                        StallClr
//               Outputs: Stall{F,D,E,M}, Flush{D,E}, Forward{AE,BE,AD,BD},
//                        StallCount, MemErr
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic [4:0]       WriteRegM;
    logic [4:0]       WriteRegW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             MemtoRegM;
    logic             BranchD;
    logic             PCSrcD;
    logic             MemReqM;
    logic             MemReadyM;
    logic             StallClr;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ForwardAD;
    logic             ForwardBD;
    logic [CNT_W-1:0] StallCount;
    logic             MemErr;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MemReqM, MemReadyM, StallClr,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallCount, MemErr
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MemReqM, MemReadyM, StallClr,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallCount, MemErr
    );

endinterface : hazard_sequencer_if
`default_nettype wire

// File: rtl/hazard_sequencer_fwd.sv
`default_nettype none
// ============================================================================
// Module      : fwd_compare
// Description : Forward-select for one source operand. Compares the operand's
//               execute-stage and decode-stage register ids against the M and
//               W destination registers. M wins over W; register 0 never
//               forwards.
//   i_src_e         : operand register id in execute
//   i_src_d         : operand register id in decode
//   i_write_reg_m/w : destination register in M / W
//   i_reg_write_m/w : destination write enable in M / W
//   o_forward_e     : ALU operand select (FWD_RF / FWD_WB / FWD_MEM)
//   o_forward_d     : branch-compare forward from M
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_compare
    import mips_pkg::*;
(
    input  wire logic [4:0] i_src_e,
    input  wire logic [4:0] i_src_d,
    input  wire logic [4:0] i_write_reg_m,
    input  wire logic [4:0] i_write_reg_w,
    input  wire logic       i_reg_write_m,
    input  wire logic       i_reg_write_w,
    output logic [1:0]      o_forward_e,
    output logic            o_forward_d
);

    logic w_m_valid;
    logic w_w_valid;
    logic w_hit_m_e;
    logic w_hit_w_e;

    assign w_m_valid = i_reg_write_m && (i_write_reg_m != 5'd0);
    assign w_w_valid = i_reg_write_w && (i_write_reg_w != 5'd0);
    assign w_hit_m_e = w_m_valid && (i_write_reg_m == i_src_e);
    assign w_hit_w_e = w_w_valid && (i_write_reg_w == i_src_e);

    assign o_forward_e = w_hit_m_e ? FWD_MEM :
                         w_hit_w_e ? FWD_WB  : FWD_RF;
    assign o_forward_d = w_m_valid && (i_write_reg_m == i_src_d);

endmodule : fwd_compare
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Hazard unit for a 5-stage pipeline. Generates stall, flush and
//               forward controls combinationally, tracks outstanding data
//               memory requests with a timeout FSM (RUN / MEM_WAIT / ERR) and
//               keeps a saturating count of stalled fetch cycles.
//   CLK : rising-edge clock
//   RST : synchronous reset, active-high (also forces controls to 0)
//   bus : hazard_sequencer_if.slave - pipeline inputs, control outputs,
//         StallCount and sticky MemErr
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    hazard_sequencer_if.slave bus
);

    // Wide enough to hold TIMEOUT plus one without wrapping
    localparam int                c_wait_w   = $clog2(TIMEOUT + 2);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
    localparam logic [c_wait_w-1:0] c_wait_lim = c_wait_w'(TIMEOUT);
    localparam logic [CNT_W-1:0]    c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_max  = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_nxt;
    logic [c_wait_w-1:0] w_wait_inc;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [1:0] w_fwd_ae;
    logic [1:0] w_fwd_be;
    logic       w_fwd_ad;
    logic       w_fwd_bd;
    logic       w_lwstall;
    logic       w_brstall;
    logic       w_memstall;
    logic       w_mem_pending;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_flush_d;
    logic       w_flush_e;

    // ------------------------------------------------------------------
    // Forwarding, one comparator per ALU operand
    // ------------------------------------------------------------------
    fwd_compare u_fwd_a (
        .i_src_e       (bus.RsE),
        .i_src_d       (bus.RsD),
        .i_write_reg_m (bus.WriteRegM),
        .i_write_reg_w (bus.WriteRegW),
        .i_reg_write_m (bus.RegWriteM),
        .i_reg_write_w (bus.RegWriteW),
        .o_forward_e   (w_fwd_ae),
        .o_forward_d   (w_fwd_ad)
    );

    fwd_compare u_fwd_b (
        .i_src_e       (bus.RtE),
        .i_src_d       (bus.RtD),
        .i_write_reg_m (bus.WriteRegM),
        .i_write_reg_w (bus.WriteRegW),
        .i_reg_write_m (bus.RegWriteM),
        .i_reg_write_w (bus.RegWriteW),
        .o_forward_e   (w_fwd_be),
        .o_forward_d   (w_fwd_bd)
    );

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_lwstall = bus.MemtoRegE && (bus.RtE != 5'd0) &&
                       ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));

    // Branch compares in decode, so a producer still in E (any ALU op) or a
    // load still in M cannot be forwarded in time.
    assign w_brstall = bus.BranchD && (
        (bus.RegWriteE && (bus.WriteRegE != 5'd0) &&
         ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD))) ||
        (bus.MemtoRegM && (bus.WriteRegM != 5'd0) &&
         ((bus.WriteRegM == bus.RsD) || (bus.WriteRegM == bus.RtD))));

    assign w_mem_pending = bus.MemReqM && !bus.MemReadyM;
    // ERR freezes the whole pipeline until reset
    assign w_memstall    = w_mem_pending || (r_state == ST_ERR);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    assign w_wait_inc = r_wait_cnt + c_wait_one;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_pending) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = c_wait_one;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.MemReadyM) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt = w_wait_inc;
                    // >= guards against a TIMEOUT of 1 never matching
                    if (w_wait_inc >= c_wait_lim) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (priority: memory stall > load/branch stall > branch)
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (RST) begin
            // all controls held inactive
        end else if (w_memstall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_flush_d = bus.PCSrcD;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter; clear beats increment
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST || bus.StallClr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_f && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.StallF     = w_stall_f;
    assign bus.StallD     = w_stall_d;
    assign bus.StallE     = w_stall_e;
    assign bus.StallM     = w_stall_m;
    assign bus.FlushD     = w_flush_d;
    assign bus.FlushE     = w_flush_e;
    assign bus.ForwardAE  = RST ? FWD_RF : w_fwd_ae;
    assign bus.ForwardBE  = RST ? FWD_RF : w_fwd_be;
    assign bus.ForwardAD  = RST ? 1'b0   : w_fwd_ad;
    assign bus.ForwardBD  = RST ? 1'b0   : w_fwd_bd;
    assign bus.StallCount = r_stall_cnt;
    assign bus.MemErr     = (r_state == ST_ERR);

endmodule : hazard_sequencer
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sequencer
// Description : Directed self-checking bench for hazard_sequencer
//               (TIMEOUT=64, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hif ();

    hazard_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (hif)
    );

    always #5 CLK = ~CLK;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    logic [5:0] w_ctl;
    assign w_ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                    hif.FlushD, hif.FlushE};

    localparam logic [5:0] CTL_NONE  = 6'b000000;
    localparam logic [5:0] CTL_LW    = 6'b110001;
    localparam logic [5:0] CTL_MEM   = 6'b111100;
    localparam logic [5:0] CTL_FLUSH = 6'b000010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        hif.RsD = 5'd0; hif.RtD = 5'd0; hif.RsE = 5'd0; hif.RtE = 5'd0;
        hif.WriteRegE = 5'd0; hif.WriteRegM = 5'd0; hif.WriteRegW = 5'd0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.BranchD = 1'b0; hif.PCSrcD = 1'b0;
        hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
        hif.StallClr = 1'b0;
    endtask

    task automatic set_lwstall();
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd5; hif.RsD = 5'd5;
    endtask

    // Safety net: directed run is far shorter than this
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_inputs();
        // ---------------- reset: controls forced to 0 -----------------
        RST = 1'b1;
        hif.MemReqM = 1'b1;
        set_lwstall();
        hif.RsE = 5'd3; hif.WriteRegM = 5'd3; hif.RegWriteM = 1'b1;
        #1;
        chk("rst_ctl", 32'(w_ctl), 32'(CTL_NONE));
        chk("rst_fwd_ae", 32'(hif.ForwardAE), 32'd0);
        tick();
        tick();
        chk("rst_cnt", 32'(hif.StallCount), 32'd0);
        chk("rst_memerr", 32'(hif.MemErr), 32'd0);
        RST = 1'b0;
        clr_inputs();
        #1;
        chk("idle_ctl", 32'(w_ctl), 32'(CTL_NONE));

        // ---------------- forwarding ----------------------------------
        hif.RsE = 5'd3; hif.RtE = 5'd3;
        hif.WriteRegM = 5'd3; hif.WriteRegW = 5'd3;
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        #1;
        chk("fwd_ae_mem", 32'(hif.ForwardAE), 32'd2);
        chk("fwd_be_mem", 32'(hif.ForwardBE), 32'd2);
        hif.WriteRegM = 5'd0;
        #1;
        chk("fwd_ae_wb", 32'(hif.ForwardAE), 32'd1);
        hif.RegWriteW = 1'b0;
        #1;
        chk("fwd_ae_rf", 32'(hif.ForwardAE), 32'd0);
        hif.RsE = 5'd0; hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd0;
        #1;
        chk("fwd_ae_r0", 32'(hif.ForwardAE), 32'd0);
        hif.RsD = 5'd3; hif.RtD = 5'd4; hif.WriteRegM = 5'd3; hif.RegWriteM = 1'b1;
        #1;
        chk("fwd_ad_hit", 32'(hif.ForwardAD), 32'd1);
        chk("fwd_bd_miss", 32'(hif.ForwardBD), 32'd0);
        hif.RtD = 5'd3; hif.RegWriteM = 1'b0;
        #1;
        chk("fwd_bd_nowr", 32'(hif.ForwardBD), 32'd0);
        chk("fwd_ctl", 32'(w_ctl), 32'(CTL_NONE));
        clr_inputs();

        // ---------------- load-use stall ------------------------------
        set_lwstall();
        #1;
        chk("lw_ctl", 32'(w_ctl), 32'(CTL_LW));
        tick();
        clr_inputs();
        #1;
        chk("lw_cnt", 32'(hif.StallCount), 32'd1);
        chk("lw_after", 32'(w_ctl), 32'(CTL_NONE));
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd0; hif.RsD = 5'd0;
        #1;
        chk("lw_r0", 32'(w_ctl), 32'(CTL_NONE));
        clr_inputs();

        // ---------------- branch --------------------------------------
        hif.PCSrcD = 1'b1;
        #1;
        chk("br_taken", 32'(w_ctl), 32'(CTL_FLUSH));
        hif.BranchD = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd7; hif.RsD = 5'd7;
        #1;
        chk("br_stall_e", 32'(w_ctl), 32'(CTL_LW));
        hif.RegWriteE = 1'b0; hif.MemtoRegM = 1'b1; hif.WriteRegM = 5'd9;
        hif.RsD = 5'd1; hif.RtD = 5'd9;
        #1;
        chk("br_stall_m", 32'(w_ctl), 32'(CTL_LW));
        clr_inputs();

        // ---------------- memory wait coincident with lwstall ---------
        hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
        set_lwstall();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memw_ctl%0d", i), 32'(w_ctl), 32'(CTL_MEM));
            tick();
        end
        hif.MemReadyM = 1'b1;
        #1;
        chk("memw_ready", 32'(w_ctl), 32'(CTL_LW));
        tick();
        clr_inputs();
        #1;
        chk("memw_cnt", 32'(hif.StallCount), 32'd5);
        hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
        #1;
        chk("mem_hit", 32'(w_ctl), 32'(CTL_NONE));
        clr_inputs();

        // ---------------- counter saturation / clear ------------------
        hif.StallClr = 1'b1;
        tick();
        hif.StallClr = 1'b0;
        chk("cnt_clr", 32'(hif.StallCount), 32'd0);
        set_lwstall();
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", 32'(hif.StallCount), 32'd14);
        tick();
        chk("cnt_15", 32'(hif.StallCount), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_sat", 32'(hif.StallCount), 32'd15);
        hif.StallClr = 1'b1;
        tick();
        chk("cnt_clr_wins", 32'(hif.StallCount), 32'd0);
        hif.StallClr = 1'b0;
        tick();
        chk("cnt_restart", 32'(hif.StallCount), 32'd1);
        clr_inputs();
        hif.StallClr = 1'b1;
        tick();
        hif.StallClr = 1'b0;

        // ---------------- timeout -> ERR -> reset ---------------------
        hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_pre_err", 32'(hif.MemErr), 32'd0);
        chk("to_pre_ctl", 32'(w_ctl), 32'(CTL_MEM));
        tick();
        chk("to_err", 32'(hif.MemErr), 32'd1);
        hif.MemReqM = 1'b0; hif.MemReadyM = 1'b1;
        #1;
        chk("err_ctl", 32'(w_ctl), 32'(CTL_MEM));
        tick(); tick(); tick();
        chk("err_sticky", 32'(hif.MemErr), 32'd1);
        chk("err_cnt", 32'(hif.StallCount), 32'd15);
        RST = 1'b1;
        hif.RsE = 5'd3; hif.WriteRegM = 5'd3; hif.RegWriteM = 1'b1;
        #1;
        chk("err_rst_ctl", 32'(w_ctl), 32'(CTL_NONE));
        chk("err_rst_fwd", 32'(hif.ForwardAE), 32'd0);
        tick();
        chk("err_rst_memerr", 32'(hif.MemErr), 32'd0);
        chk("err_rst_cnt", 32'(hif.StallCount), 32'd0);
        RST = 1'b0;
        clr_inputs();
        hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
        #1;
        chk("run_after_rst", 32'(w_ctl), 32'(CTL_NONE));
        hif.MemReadyM = 1'b0;
        #1;
        chk("run_memstall", 32'(w_ctl), 32'(CTL_MEM));
        tick();
        hif.MemReadyM = 1'b1;
        tick();
        clr_inputs();
        #1;
        chk("final_memerr", 32'(hif.MemErr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_sequencer
`default_nettype wire

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 64, memory-wait cycles before error.
REQ-002 Parameter: CNT_W, 16, stall-counter width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 RsD, RtD  input  5 each  decode-stage source registers.
REQ-007 RsE, RtE  input  5 each  execute-stage source registers.
REQ-008 WriteRegE, WriteRegM, WriteRegW  input  5 each  destination register per stage.
REQ-009 RegWriteE, RegWriteM, RegWriteW  input  1 each  destination write enable per stage.
REQ-010 MemtoRegE, MemtoRegM  input  1 each  load in E / M.
REQ-011 BranchD, PCSrcD  input  1 each  branch in decode / branch taken.
REQ-012 MemReqM, MemReadyM  input  1 each  data-memory request / ready.
REQ-013 StallClr  input  1  clears stall counter.
REQ-014 StallF, StallD, StallE, StallM  output  1 each  hold the PC / F-D / D-E / E-M registers.
REQ-015 FlushD, FlushE  output  1 each  clear the F-D / D-E registers (FlushE drives the D-E register CLR).
REQ-016 ForwardAE, ForwardBE  output  2 each  ALU operand source select.
REQ-017 ForwardAD, ForwardBD  output  1 each  branch-compare forward from M.
REQ-018 StallCount  output  CNT_W  saturating count of stalled cycles.
REQ-019 MemErr  output  1  sticky memory-timeout flag.

Function
REQ-020 ForwardAE SHALL be 10 if RegWriteM, WriteRegM!=0 and WriteRegM==RsE; else 01 if RegWriteW, WriteRegW!=0 and WriteRegW==RsE; else 00. ForwardBE is identical using RtE. M has priority over W.
REQ-021 ForwardAD SHALL be 1 iff RegWriteM, WriteRegM!=0 and WriteRegM==RsD. ForwardBD is identical using RtD.
REQ-022 lwstall SHALL be MemtoRegE & RtE!=0 & (RtE==RsD | RtE==RtD).
REQ-023 brstall SHALL be BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE matches RsD/RtD) | (MemtoRegM & WriteRegM!=0 & WriteRegM matches RsD/RtD)).
REQ-024 memstall SHALL be (MemReqM & !MemReadyM) | state==ERR.
REQ-025 If memstall: StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0. This case overrides all others.
REQ-026 Else if lwstall|brstall: StallF=StallD=1, StallE=StallM=0, FlushE=1, FlushD=0.
REQ-027 Else: all stalls 0, FlushE=0, FlushD=PCSrcD.
REQ-028 FSM states SHALL be RUN, MEM_WAIT and ERR, with these transitions:
  - RUN->MEM_WAIT on MemReqM & !MemReadyM, loading wait counter with 1.
  - MEM_WAIT->RUN on MemReadyM.
  - MEM_WAIT stays on !MemReadyM, with wait counter +1.
  - MEM_WAIT->ERR when the wait counter reaches TIMEOUT with MemReadyM=0.
  - ERR is terminal until RST.
REQ-029 MemErr SHALL be 1 exactly while state==ERR.
REQ-030 StallCount SHALL increment on each cycle with StallF=1, saturate at 2^CNT_W-1, and clear to 0 on StallClr. Clear wins over a simultaneous increment.
REQ-031 All outputs except StallCount/MemErr SHALL be combinational, with zero-cycle latency.

Reset
REQ-032 While RST=1 the block SHALL drive all Stall*/Flush* outputs to 0 and Forward* to 0.
REQ-033 On RST=1 at a clock edge: state=RUN, wait counter=0, StallCount=0, MemErr=0. This applies mid-wait and in ERR.

Structure
REQ-034 Package mips_pkg SHALL hold the state enum and the forward encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-035 Sub-module fwd_compare SHALL implement REQ-020/021 and be instantiated twice (A and B operands).

Verification
REQ-036 Load-use: MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 for 1 cycle, StallCount=1.
REQ-037 Double forward: RsE=3, WriteRegM=3, WriteRegW=3, both RegWrite=1 -> ForwardAE=10. With WriteRegM=0 -> ForwardAE=01.
REQ-038 Memory wait: MemReqM=1, MemReadyM low 3 cycles, coincident with lwstall -> all four stalls 1 for 3 cycles, FlushE=0, state returns to RUN.
REQ-039 Timeout: MemReadyM held 0 for TIMEOUT=64 cycles -> MemErr=1 and stalls stay 1. Then RST=1 -> MemErr=0, state RUN.
REQ-040 Branch taken: PCSrcD=1, no hazards -> FlushD=1. Same cycle with brstall -> FlushD=0, FlushE=1.
REQ-041 Counter: CNT_W=4, 20 stall cycles -> StallCount=15. StallClr concurrent with a stall -> 0.
